bus_arbiter: RTL and testbench

Arbitrates ownership of the 68k local bus between the CPU and two external bus masters (DMA or expansion-slot cards) using the 68000 BR/BG/BGACK protocol. It collects the masters' requests, drives a single bus request to the CPU, and routes the CPU's bus grant to exactly one master using round-robin priority. A grant-acknowledge timeout reclaims the bus from masters that never take it. It sits in the glue logic alongside the address decoder and DTACK/BERR generation, clocked from the CPU clock.

---
 rtl/bus_arbiter_if.sv | 23 ++
 rtl/bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_bus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// 68k bus-arbitration signal bundle between the bus masters/CPU and the arbiter.
// The slave modport is the arbiter's view; master is the requesting side.
interface bus_arbiter_if;
    logic [1:0] REQn;
    logic       BGn;
    logic       ASn;
    logic       BGACKn;
    logic       BRn;
    logic [1:0] GNTn;
    logic       OWNER;
    logic       BUSY;
    logic       TOIRQ;

    modport slave (
        input  REQn, BGn, ASn, BGACKn,
        output BRn, GNTn, OWNER, BUSY, TOIRQ
    );

    modport master (
        output REQn, BGn, ASn, BGACKn,
        input  BRn, GNTn, OWNER, BUSY, TOIRQ
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin BR/BG/BGACK arbiter handing the 68k bus from the CPU to one of two
// external masters, with a grant-acknowledge timeout that reclaims unused grants.
module bus_arbiter #(
    parameter int unsigned GRANT_TO = 16
) (
    input logic          CLK,
    input logic          RESETn,
    bus_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_AS,
        GRANT,
        OWNED,
        RELEASE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(GRANT_TO - 1);

    state_t     state;
    logic [1:0] req_m, req_s;
    logic [2:0] ctl_m, ctl_s;
    logic       bg_s, as_s, bgack_s;
    logic       any_req, sel, last;
    logic [7:0] cnt;
    logic       brn_r, owner_r, busy_r, toirq_r;
    logic [1:0] gntn_r;

    // Two-flop synchronisers; ctl bundles {BGn, ASn, BGACKn}, all idle-high.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            req_m <= '1;
            req_s <= '1;
            ctl_m <= '1;
            ctl_s <= '1;
        end else begin
            req_m <= bus.REQn;
            req_s <= req_m;
            ctl_m <= {bus.BGn, bus.ASn, bus.BGACKn};
            ctl_s <= ctl_m;
        end
    end

    assign bg_s    = ctl_s[2];
    assign as_s    = ctl_s[1];
    assign bgack_s = ctl_s[0];
    assign any_req = ~&req_s;

    // Lone requester wins outright; on a tie the master that was not granted last wins.
    always_comb begin
        if (req_s == 2'b00) sel = ~last;
        else                sel = req_s[0];
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state   <= IDLE;
            brn_r   <= 1'b1;
            gntn_r  <= '1;
            owner_r <= 1'b0;
            busy_r  <= 1'b0;
            toirq_r <= 1'b0;
            last    <= 1'b1;
            cnt     <= '0;
        end else begin
            toirq_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= REQ;
                        brn_r <= 1'b0;
                    end
                end
                REQ: begin
                    if (!any_req) begin
                        state <= IDLE;
                        brn_r <= 1'b1;
                    end else if (!bg_s) begin
                        state <= WAIT_AS;
                    end
                end
                WAIT_AS: begin
                    if (!any_req) begin
                        state <= IDLE;
                        brn_r <= 1'b1;
                    end else if (as_s && bgack_s) begin
                        state   <= GRANT;
                        owner_r <= sel;
                        last    <= sel;
                        gntn_r  <= sel ? 2'b01 : 2'b10;
                        cnt     <= '0;
                    end
                end
                GRANT: begin
                    if (!bgack_s) begin
                        state  <= OWNED;
                        brn_r  <= 1'b1;
                        busy_r <= 1'b1;
                    end else if (req_s[owner_r]) begin
                        state   <= RELEASE;
                        brn_r   <= 1'b1;
                        gntn_r  <= '1;
                        owner_r <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= RELEASE;
                        brn_r   <= 1'b1;
                        gntn_r  <= '1;
                        owner_r <= 1'b0;
                        toirq_r <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                OWNED: begin
                    if (bgack_s) begin
                        state   <= RELEASE;
                        gntn_r  <= '1;
                        owner_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (any_req) begin
                        state <= REQ;
                        brn_r <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    brn_r   <= 1'b1;
                    gntn_r  <= '1;
                    owner_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.BRn   = brn_r;
    assign bus.GNTn  = gntn_r;
    assign bus.OWNER = owner_r;
    assign bus.BUSY  = busy_r;
    assign bus.TOIRQ = toirq_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboarded bench for bus_arbiter: round-based random master traffic, a CPU model
// answering BR with BG, and a monitor checking every grant against a round-robin model.
module tb_bus_arbiter;

    localparam int unsigned GRANT_TO = 16;
    localparam int TAKE   = 0;
    localparam int IGNORE = 1;
    localparam int ABORT  = 2;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    logic req0 = 1'b1, req1 = 1'b1, bgk0 = 1'b1, bgk1 = 1'b1;

    bus_arbiter_if bif ();

    bus_arbiter #(.GRANT_TO(GRANT_TO)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bif.slave)
    );

    always #5 CLK = ~CLK;

    assign bif.REQn   = {req1, req0};
    assign bif.BGACKn = bgk0 & bgk1;

    typedef struct {
        int idx;
        bit tmo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   last_m = 1;
    logic [3:0] as_h = '1;
    logic [3:0] bk_h = '1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Input values seen at each rising edge; index k is the edge k cycles back.
    always @(posedge CLK) begin
        as_h <= {as_h[2:0], bif.ASn};
        bk_h <= {bk_h[2:0], bif.BGACKn};
    end

    // CPU: BG follows BR three cycles late; AS toggles in random bursts while no master holds a grant.
    initial begin : cpu
        logic [2:0] d;
        int run;
        d = '1;
        run = 0;
        bif.BGn = 1'b1;
        bif.ASn = 1'b1;
        forever begin
            @(negedge CLK);
            d = {d[1:0], bif.BRn};
            bif.BGn = d[2];
            if (run == 0) begin
                bif.ASn = (bif.GNTn == 2'b11) ? 1'($urandom_range(0, 1)) : 1'b1;
                run = $urandom_range(1, 6);
            end
            run--;
        end
    end

    initial begin : monitor
        logic [1:0] prev_gnt;
        logic prev_busy;
        int glen;
        exp_t cur;
        prev_gnt = 2'b11;
        prev_busy = 1'b0;
        glen = 0;
        cur = '{idx: 0, tmo: 1'b0};
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                chk("gnt_onehot", int'(bif.GNTn != 2'b00), 1);
                chk("owner", int'(bif.OWNER), (bif.GNTn == 2'b01) ? 1 : 0);
                chk("busy", int'(bif.BUSY), (bif.GNTn != 2'b11 && bif.BRn) ? 1 : 0);
                if (prev_gnt == 2'b11 && bif.GNTn != 2'b11) begin
                    glen = 1;
                    if (sb.size() == 0) begin
                        chk("unexpected_grant", int'(bif.GNTn), 3);
                        cur = '{idx: -1, tmo: 1'b0};
                    end else begin
                        cur = sb.pop_front();
                        chk("grant_idx", (bif.GNTn == 2'b01) ? 1 : 0, cur.idx);
                        chk("grant_as_high", int'(as_h[2]), 1);
                        chk("grant_bgack_high", int'(bk_h[2]), 1);
                    end
                    chk("toirq_quiet", int'(bif.TOIRQ), 0);
                end else if (prev_gnt != 2'b11 && bif.GNTn == 2'b11) begin
                    if (cur.tmo) begin
                        chk("timeout_len", glen, GRANT_TO);
                        chk("toirq_pulse", int'(bif.TOIRQ), 1);
                    end else begin
                        chk("toirq_none", int'(bif.TOIRQ), 0);
                        chk("release_latency", int'({bk_h[3], bk_h[2]}), 1);
                    end
                end else begin
                    if (bif.GNTn != 2'b11) glen++;
                    chk("toirq_quiet", int'(bif.TOIRQ), 0);
                end
                if (!prev_busy && bif.BUSY)
                    chk("busy_latency", int'({bk_h[3], bk_h[2]}), 2);
            end
            prev_gnt = bif.GNTn;
            prev_busy = bif.BUSY;
        end
    end

    task automatic set_req(input int idx, input logic v);
        if (idx == 0) req0 = v;
        else          req1 = v;
    endtask

    task automatic set_bgk(input int idx, input logic v);
        if (idx == 0) bgk0 = v;
        else          bgk1 = v;
    endtask

    task automatic wait_gnt(input int idx, input logic level, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (bif.GNTn[idx] == level) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk($sformatf("wait_gnt%0d", idx), int'(bif.GNTn[idx]), int'(level));
    endtask

    // Request already asserted on entry; acts out one bus tenure in the given mode.
    task automatic master(input int idx, input int mode, input int hold);
        bit ok;
        if (mode == ABORT) begin
            set_req(idx, 1'b1);
            @(negedge CLK); chk("abort_brn_hold", int'(bif.BRn), 0);
            @(negedge CLK); chk("abort_brn_hold", int'(bif.BRn), 0);
            @(negedge CLK); chk("abort_brn_drop", int'(bif.BRn), 1);
            return;
        end
        wait_gnt(idx, 1'b0, ok);
        if (!ok) begin
            set_req(idx, 1'b1);
            return;
        end
        if (mode == TAKE) begin
            repeat (2) @(negedge CLK);
            set_bgk(idx, 1'b0);
            repeat (hold) @(negedge CLK);
            set_bgk(idx, 1'b1);
            set_req(idx, 1'b1);
            wait_gnt(idx, 1'b1, ok);
        end else begin
            wait_gnt(idx, 1'b1, ok);
            set_req(idx, 1'b1);
        end
    endtask

    task automatic wait_quiet();
        int q;
        q = 0;
        for (int i = 0; i < 400 && q < 8; i++) begin
            @(negedge CLK);
            if (bif.BRn && bif.BGn && bif.GNTn == 2'b11 && req0 && req1 && bgk0 && bgk1) q++;
            else q = 0;
        end
        if (q < 8) chk("quiet", q, 8);
    endtask

    task automatic run_round(input logic [1:0] mask, input int md0, input int md1);
        int h0, h1, first, m;
        h0 = $urandom_range(1, 8);
        h1 = $urandom_range(1, 8);
        if (mask == 2'b11) begin
            // Tie: the non-LAST master goes first, then LAST; LAST ends where it started.
            first = 1 - last_m;
            sb.push_back('{idx: first, tmo: (((first == 0) ? md0 : md1) == IGNORE)});
            sb.push_back('{idx: last_m, tmo: (((last_m == 0) ? md0 : md1) == IGNORE)});
        end else begin
            m = mask[0] ? 0 : 1;
            if (((m == 0) ? md0 : md1) != ABORT) begin
                sb.push_back('{idx: m, tmo: (((m == 0) ? md0 : md1) == IGNORE)});
                last_m = m;
            end
        end
        if (mask[0]) req0 = 1'b0;
        if (mask[1]) req1 = 1'b0;
        @(negedge CLK); chk("brn_latency", int'(bif.BRn), 1);
        @(negedge CLK); chk("brn_latency", int'(bif.BRn), 1);
        @(negedge CLK); chk("brn_latency", int'(bif.BRn), 0);
        fork
            begin if (mask[0]) master(0, md0, h0); end
            begin if (mask[1]) master(1, md1, h1); end
        join
        wait_quiet();
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        bit ok;
        logic [1:0] mask;
        int md0, md1;

        repeat (3) @(negedge CLK);
        chk("rst_brn",   int'(bif.BRn),   1);
        chk("rst_gntn",  int'(bif.GNTn),  3);
        chk("rst_owner", int'(bif.OWNER), 0);
        chk("rst_busy",  int'(bif.BUSY),  0);
        chk("rst_toirq", int'(bif.TOIRQ), 0);
        RESETn = 1'b1;
        mon_en = 1'b1;
        wait_quiet();

        run_round(2'b11, TAKE, TAKE);
        run_round(2'b11, TAKE, TAKE);
        run_round(2'b01, TAKE, TAKE);
        run_round(2'b11, TAKE, IGNORE);
        run_round(2'b10, TAKE, ABORT);

        for (int r = 0; r < 40; r++) begin
            mask = 2'($urandom_range(1, 3));
            md0 = ($urandom_range(0, 3) == 0) ? IGNORE : TAKE;
            md1 = ($urandom_range(0, 3) == 0) ? IGNORE : TAKE;
            if (mask != 2'b11 && $urandom_range(0, 4) == 0) begin
                md0 = ABORT;
                md1 = ABORT;
            end
            run_round(mask, md0, md1);
        end

        // Reset while master 0 owns the bus.
        mon_en = 1'b0;
        req0 = 1'b0;
        wait_gnt(0, 1'b0, ok);
        repeat (2) @(negedge CLK);
        bgk0 = 1'b0;
        for (int i = 0; i < 50 && !bif.BUSY; i++) @(negedge CLK);
        chk("pre_reset_busy", int'(bif.BUSY), 1);
        RESETn = 1'b0;
        @(negedge CLK);
        chk("mid_rst_brn",   int'(bif.BRn),   1);
        chk("mid_rst_gntn",  int'(bif.GNTn),  3);
        chk("mid_rst_busy",  int'(bif.BUSY),  0);
        chk("mid_rst_owner", int'(bif.OWNER), 0);
        chk("mid_rst_toirq", int'(bif.TOIRQ), 0);
        RESETn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            chk("held_bgack_no_grant", int'(bif.GNTn), 3);
        end
        bgk0 = 1'b1;
        req0 = 1'b1;
        wait_quiet();
        last_m = 1;
        mon_en = 1'b1;
        run_round(2'b11, TAKE, TAKE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
